dht11_frame_ctrl: RTL
=====================

Name: dht11_frame_ctrl

Overview:
- Sequencer and packetizer directly downstream of the DHT11 single-wire reader.
- On a request, it kicks the reader through its enable/reset pins and waits for the read to complete.
- It then latches the 40-bit frame, checks the checksum and streams a status and data byte frame to the UART TX stage over a valid/ready handshake.
- Sits between the UART command decoder (i_Req) and the UART transmitter.

Parameters:
- TIMEOUT_CYCLES, 5_000_000: max cycles in BUSY waiting for i_Dht_Wait to fall (100 ms at 50 MHz).
- ARM_CYCLES, 16: max cycles in ARM waiting for i_Dht_Wait to rise.

Ports:
- i_Clock  in  1  system clock, 50 MHz
- i_Rst  in  1  synchronous active-high reset
- i_Req  in  1  one-cycle read request; ignored unless in IDLE
- o_Busy  out  1  high in every state except IDLE
- o_Dht_En  out  1  reader enable
- o_Dht_Rst  out  1  reader reset pulse
- i_Dht_Data  in  40  reader frame; bit 39 = first bit received
- i_Dht_Wait  in  1  reader busy
- i_Dht_Error  in  1  reader error flag
- o_Tx_Data  out  8  byte to UART TX
- o_Tx_Valid  out  1  byte valid
- i_Tx_Ready  in  1  TX accepts byte
- o_Done  out  1  one-cycle pulse after last byte accepted
- o_Status  out  8  status of last completed read

Behaviour:
- Reset: clock i_Clock; reset i_Rst, synchronous, active-high. All outputs 0, o_Status = 0x00, state IDLE. Reset mid-operation aborts any read or frame; no partial bytes follow.
- Frame fields: hum_int = [39:32], hum_dec = [31:24], tmp_int = [23:16], tmp_dec = [15:8], cs = [7:0].
- Status codes: 0x00 OK, 0x1F sensor error, 0x2F checksum error, 0x3F timeout.
- IDLE: o_Dht_En = 0, which freezes the reader. i_Req = 1 goes to KICK.
- KICK: one cycle with o_Dht_En = 1 and o_Dht_Rst = 1. Clears the sticky error flag and the counter. Goes to ARM.
- ARM: o_Dht_En = 1. i_Dht_Wait = 1 goes to BUSY with counter cleared. If the counter reaches ARM_CYCLES, record timeout and go to LATCH.
- BUSY: o_Dht_En = 1.
  - The sticky error flag is set whenever i_Dht_Error = 1. It is required because the reader drops Error in the same cycle Wait falls.
  - i_Dht_Wait = 0 goes to LATCH.
  - If the counter reaches TIMEOUT_CYCLES, record timeout and go to LATCH.
- LATCH: one cycle, o_Dht_En = 0. Status priority is timeout > sticky error > checksum mismatch > OK.
  - Checksum: (hum_int + hum_dec + tmp_int + tmp_dec) mod 256 must equal cs.
  - o_Status is updated here.
  - Data bytes are latched as received when OK, and forced to 0x00 otherwise.
  - Byte index cleared; goes to SEND.
- SEND: o_Tx_Valid = 1 with o_Tx_Data = byte[idx]. Data stays stable while i_Tx_Ready = 0.
  - A transfer occurs on a clock edge where valid and ready are both 1; idx increments and the next byte is presented the following cycle, back-to-back allowed.
  - The edge that transfers the last byte moves to DONE, with o_Tx_Valid = 0 in DONE.
- DONE: o_Done = 1 for one cycle; goes to IDLE.
- Default frame is 3 bytes: status, hum_int, tmp_int.
- Latency: KICK follows the i_Req edge by 1 cycle. The first o_Tx_Valid is asserted 1 cycle after BUSY exits.
- Counter width: $clog2(TIMEOUT_CYCLES+1). Counting saturates and never wraps.

Optional Feature:
- DHT_FRAME_DECIMALS_EN defined: frame is 5 bytes, in order status, hum_int, hum_dec, tmp_int, tmp_dec.
- Undefined: 3-byte frame; the decimal registers are not synthesised.

Decomposition:
- dht_pkg holds:
  - status code localparams;
  - state enum;
  - frame byte-count constant, selected by the macro;
  - field slice offsets.
- Sub-module dht11_checksum: 40-bit frame in, 1-bit match out; combinational. Instantiated in LATCH datapath.

Test Plan:
- OK frame: Data = 0x2D00190046, Wait rises then falls, Ready always 1 -> bytes 0x00, 0x2D, 0x19 on consecutive cycles; o_Done pulse; o_Status = 0x00.
- Checksum error: Data = 0x2D00190047 -> bytes 0x2F, 0x00, 0x00; o_Status = 0x2F.
- Sensor error: Error high for 3 cycles mid-BUSY, then Wait falls with Error = 0 and Data = 0 -> bytes 0x1F, 0x00, 0x00.
- Timeout, bench TIMEOUT_CYCLES = 1000: Wait stuck at 1 -> LATCH after 1000 BUSY cycles, o_Dht_En low, bytes 0x3F, 0x00, 0x00. Separately, Wait never rises -> 0x3F after ARM_CYCLES.
- Backpressure: Ready low for 5 cycles before each byte -> each byte is held stable and delivered exactly once. An i_Req pulse during SEND is ignored.
- Reset in SEND after the first byte -> next cycle Valid = 0, En = 0, Status = 0x00. A new i_Req then yields a full correct frame.

Source files
------------

// File: rtl/dht_pkg.sv
// Shared constants for the DHT11 frame controller: status codes, FSM states, frame layout.
// DHT_FRAME_DECIMALS_EN selects the 5-byte frame (status, hum_int, hum_dec, tmp_int, tmp_dec).
package dht_pkg;

    localparam logic [7:0] ST_OK         = 8'h00;
    localparam logic [7:0] ST_SENSOR_ERR = 8'h1F;
    localparam logic [7:0] ST_CSUM_ERR   = 8'h2F;
    localparam logic [7:0] ST_TIMEOUT    = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KICK,
        S_ARM,
        S_BUSY,
        S_LATCH,
        S_SEND,
        S_DONE
    } state_t;

`ifdef DHT_FRAME_DECIMALS_EN
    localparam int FRAME_BYTES = 5;
`else
    localparam int FRAME_BYTES = 3;
`endif

    localparam int IDX_W = 3;

    localparam int HUM_INT_LSB = 32;
    localparam int HUM_DEC_LSB = 24;
    localparam int TMP_INT_LSB = 16;
    localparam int TMP_DEC_LSB = 8;
    localparam int CS_LSB      = 0;

    function automatic logic [7:0] field(input logic [39:0] frame, input int lsb);
        return frame[lsb +: 8];
    endfunction

endpackage

// File: rtl/dht11_frame_ctrl_if.sv
// Byte stream from the frame controller to the UART transmitter (valid/ready).
interface dht11_frame_ctrl_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/dht11_checksum.sv
// Combinational DHT11 checksum: low byte of the four data bytes' sum must equal the checksum byte.
module dht11_checksum
    import dht_pkg::*;
(
    input  logic [39:0] frame,
    output logic        match
);

    logic [7:0] sum;

    always_comb begin
        sum   = field(frame, HUM_INT_LSB) + field(frame, HUM_DEC_LSB)
              + field(frame, TMP_INT_LSB) + field(frame, TMP_DEC_LSB);
        match = (sum == field(frame, CS_LSB));
    end

endmodule

// File: rtl/dht11_frame_ctrl.sv
// Sequences one DHT11 read, classifies the result and streams status + data bytes to UART TX.
// Define DHT_FRAME_DECIMALS_EN to include the decimal bytes in the frame.
module dht11_frame_ctrl
    import dht_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int ARM_CYCLES     = 16
) (
    input  logic                       i_Clock,
    input  logic                       i_Rst,
    input  logic                       i_Req,
    output logic                       o_Busy,
    output logic                       o_Dht_En,
    output logic                       o_Dht_Rst,
    input  logic [39:0]                i_Dht_Data,
    input  logic                       i_Dht_Wait,
    input  logic                       i_Dht_Error,
    dht11_frame_ctrl_if.master         tx,
    output logic                       o_Done,
    output logic [7:0]                 o_Status
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ARM_LAST     = CNT_W'(ARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
    endfunction

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             err_sticky;
    logic             timed_out;
    logic [IDX_W-1:0] idx;
    logic             csum_ok;
    logic [7:0]       status_nxt;
    logic [7:0]       tx_byte;
    logic             arm_expire, busy_expire, last_byte;
    logic [7:0]       hum_int, tmp_int;
`ifdef DHT_FRAME_DECIMALS_EN
    logic [7:0]       hum_dec, tmp_dec;
`endif

    dht11_checksum u_checksum (
        .frame (i_Dht_Data),
        .match (csum_ok)
    );

    assign arm_expire  = (state == S_ARM)  && !i_Dht_Wait && (cnt >= ARM_LAST);
    assign busy_expire = (state == S_BUSY) &&  i_Dht_Wait && (cnt >= TIMEOUT_LAST);
    assign last_byte   = (idx == IDX_W'(FRAME_BYTES - 1));

    // Timeout outranks the sticky error, which outranks a checksum mismatch.
    assign status_nxt = timed_out  ? ST_TIMEOUT :
                        err_sticky ? ST_SENSOR_ERR :
                        !csum_ok   ? ST_CSUM_ERR : ST_OK;

    always_ff @(posedge i_Clock) begin
        if (i_Rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_Req) state_nxt = S_KICK;
            S_KICK:  state_nxt = S_ARM;
            S_ARM:   if (i_Dht_Wait) state_nxt = S_BUSY;
                     else if (arm_expire) state_nxt = S_LATCH;
            S_BUSY:  if (!i_Dht_Wait || busy_expire) state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_SEND;
            S_SEND:  if (tx.tx_ready && last_byte) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_Busy      = (state != S_IDLE);
        o_Dht_En    = (state == S_KICK) || (state == S_ARM) || (state == S_BUSY);
        o_Dht_Rst   = (state == S_KICK);
        tx.tx_valid = (state == S_SEND);
        tx.tx_data  = (state == S_SEND) ? tx_byte : 8'h00;
        o_Done      = (state == S_DONE);
    end

    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            cnt        <= '0;
            err_sticky <= 1'b0;
            timed_out  <= 1'b0;
            idx        <= '0;
            o_Status   <= ST_OK;
        end else begin
            case (state)
                S_KICK: begin
                    cnt        <= '0;
                    err_sticky <= 1'b0;
                    timed_out  <= 1'b0;
                end
                S_ARM: begin
                    cnt <= i_Dht_Wait ? '0 : sat_inc(cnt);
                    if (arm_expire) timed_out <= 1'b1;
                end
                S_BUSY: begin
                    // Error drops together with Wait, so it must be remembered here.
                    if (i_Dht_Error) err_sticky <= 1'b1;
                    cnt <= sat_inc(cnt);
                    if (busy_expire) timed_out <= 1'b1;
                end
                S_LATCH: begin
                    o_Status <= status_nxt;
                    idx      <= '0;
                end
                S_SEND:  if (tx.tx_ready && !last_byte) idx <= idx + IDX_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_Clock) begin
        if (state == S_LATCH) begin
            hum_int <= (status_nxt == ST_OK) ? field(i_Dht_Data, HUM_INT_LSB) : 8'h00;
            tmp_int <= (status_nxt == ST_OK) ? field(i_Dht_Data, TMP_INT_LSB) : 8'h00;
`ifdef DHT_FRAME_DECIMALS_EN
            hum_dec <= (status_nxt == ST_OK) ? field(i_Dht_Data, HUM_DEC_LSB) : 8'h00;
            tmp_dec <= (status_nxt == ST_OK) ? field(i_Dht_Data, TMP_DEC_LSB) : 8'h00;
`endif
        end
    end

    always_comb begin
        tx_byte = 8'h00;
        case (idx)
            3'd0: tx_byte = o_Status;
`ifdef DHT_FRAME_DECIMALS_EN
            3'd1: tx_byte = hum_int;
            3'd2: tx_byte = hum_dec;
            3'd3: tx_byte = tmp_int;
            3'd4: tx_byte = tmp_dec;
`else
            3'd1: tx_byte = hum_int;
            3'd2: tx_byte = tmp_int;
`endif
            default: tx_byte = 8'h00;
        endcase
    end

endmodule
